// File: rtl/rmii_tx_framer.sv
// 100 Mb/s RMII transmit framer: preamble, SFD, payload, zero pad, FCS and inter-frame gap as LSB-first dibits.
// FCS generation is compiled in when RMII_TX_FCS_EN is defined; otherwise software supplies the FCS in the payload.
module rmii_tx_framer #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int IFG_BYTES       = 12
) (
    input  logic       clk_rmii,
    input  logic       rst_ni,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] txd,
    output logic       tx_en,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    localparam int PRE_CYC = PREAMBLE_BYTES * 4;
    localparam int IFG_CYC = IFG_BYTES * 4;
    localparam int CNT_MAX = (PRE_CYC > IFG_CYC) ? ((PRE_CYC > 16) ? PRE_CYC : 16)
                                                 : ((IFG_CYC > 16) ? IFG_CYC : 16);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // The IDLE cycle that launches the next preamble is the final gap cycle.
    localparam int IFG_STATE_CYC = (IFG_CYC > 1) ? IFG_CYC - 1 : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_STATE_CYC - 1);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);
    localparam logic [15:0]      MIN_B    = 16'(MIN_FRAME_BYTES);

`ifdef RMII_TX_FCS_EN
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;
    localparam state_t S_TAIL = S_FCS;
    localparam bit     FCS_EN = 1'b1;
`else
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_IFG} state_t;
    localparam state_t S_TAIL = S_IFG;
    localparam bit     FCS_EN = 1'b0;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       dib, dib_n;
    logic [7:0]       byte_q, byte_n;
    logic             last_q, last_n;
    logic [15:0]      bcnt, bcnt_n;
    logic             fetch;
    logic [1:0]       txd_p0;
    logic             txen_p0, done_p0, urun_p0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v < MIN_B) ? v + 16'd1 : v;
    endfunction

`ifdef RMII_TX_FCS_EN
    logic        crc_init, crc_en, bad_q;
    logic [31:0] crc_q, fcs_word;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign crc_init = (state == S_IDLE) && s_valid;
    assign crc_en   = (state == S_DATA) || (state == S_PAD);
    // A truncated frame carries the raw CRC so the receiver discards it.
    assign fcs_word = bad_q ? crc_q : ~crc_q;

    always_ff @(posedge clk_rmii) begin
        if (crc_init)
            crc_q <= 32'hFFFF_FFFF;
        else if (crc_en)
            crc_q <= crc_dibit(crc_q, txd_p0);
    end

    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni)
            bad_q <= 1'b0;
        else if (crc_init)
            bad_q <= 1'b0;
        else if (urun_p0)
            bad_q <= 1'b1;
    end
`endif

    assign busy = (state != S_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dib_n   = dib;
        byte_n  = byte_q;
        last_n  = last_q;
        bcnt_n  = bcnt;
        fetch   = 1'b0;
        s_ready = 1'b0;
        txd_p0  = 2'b00;
        txen_p0 = 1'b0;
        done_p0 = 1'b0;
        urun_p0 = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_valid) begin
                    state_n = S_PRE;
                    cnt_n   = '0;
                    last_n  = 1'b0;
                    bcnt_n  = '0;
                end
            end
            S_PRE: begin
                txen_p0 = 1'b1;
                txd_p0  = 2'b01;
                if (cnt == PRE_LAST) begin
                    state_n = S_SFD;
                    cnt_n   = '0;
                    dib_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_SFD: begin
                txen_p0 = 1'b1;
                txd_p0  = (dib == 2'd3) ? 2'b11 : 2'b01;
                dib_n   = dib + 2'd1;
                fetch   = (dib == 2'd3);
            end
            S_DATA: begin
                txen_p0 = 1'b1;
                txd_p0  = byte_q[{dib, 1'b0} +: 2];
                dib_n   = dib + 2'd1;
                if (dib == 2'd3) begin
                    if (!last_q) begin
                        fetch = 1'b1;
                    end else if (bcnt < MIN_B) begin
                        state_n = S_PAD;
                    end else begin
                        state_n = S_TAIL;
                        cnt_n   = '0;
                        done_p0 = !FCS_EN;
                    end
                end
            end
            S_PAD: begin
                txen_p0 = 1'b1;
                dib_n   = dib + 2'd1;
                if (dib == 2'd3) begin
                    bcnt_n = sat_inc(bcnt);
                    if (sat_inc(bcnt) >= MIN_B) begin
                        state_n = S_TAIL;
                        cnt_n   = '0;
                        done_p0 = !FCS_EN;
                    end
                end
            end
`ifdef RMII_TX_FCS_EN
            S_FCS: begin
                txen_p0 = 1'b1;
                txd_p0  = fcs_word[{cnt[3:0], 1'b0} +: 2];
                if (cnt == FCS_LAST) begin
                    state_n = S_IFG;
                    cnt_n   = '0;
                    done_p0 = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            S_IFG: begin
                if (cnt >= IFG_LAST)
                    state_n = S_IDLE;
                else
                    cnt_n = cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        // Byte request on the last dibit of SFD or of the previous byte.
        if (fetch) begin
            s_ready = 1'b1;
            if (s_valid) begin
                byte_n  = s_data;
                last_n  = s_last;
                bcnt_n  = sat_inc(bcnt);
                state_n = S_DATA;
            end else begin
                urun_p0 = 1'b1;
                state_n = S_TAIL;
                cnt_n   = '0;
            end
        end
    end

    // Output stage: registered dibit, enable and status pulses.
    always_ff @(posedge clk_rmii or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dib        <= '0;
            last_q     <= 1'b0;
            bcnt       <= '0;
            txd        <= 2'b00;
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dib        <= dib_n;
            last_q     <= last_n;
            bcnt       <= bcnt_n;
            txd        <= txd_p0;
            tx_en      <= txen_p0;
            frame_done <= done_p0;
            underrun   <= urun_p0;
        end
    end

    always_ff @(posedge clk_rmii) begin
        byte_q <= byte_n;
    end

endmodule
